// File: rtl/count_disp_pkg.sv
// count_disp_pkg: seven-segment codes (active-high, g..a in [6:0]) and digit-select type
// shared by the count display top and its encoder.
package count_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        DIG_ONES = 1'b0,
        DIG_TENS = 1'b1
    } dig_sel_e;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: combinational BCD digit to seven-segment code with selectable polarity.
module seg7_encode
    import count_disp_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    assign seg_o = ACTIVE_LOW ? ~seg_code(digit_i) : seg_code(digit_i);

endmodule

// File: rtl/count_seg_display.sv
// count_seg_display: captures a 0-15 count, splits it to tens/ones, drives a muxed two-digit
// seven-segment display and pulses wrap on 15->0. COUNT_DISP_BLANK_EN blanks a leading-zero tens digit.
module count_seg_display
    import count_disp_pkg::*;
#(
    parameter int REFRESH_DIV    = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] q_in,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       wrap
);

    localparam int            DW       = $clog2(REFRESH_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [6:0]    SEG_OFF  = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
    localparam logic [1:0]    AN_OFF   = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

    logic [3:0]    cnt_q, ones_q, ones_d, digit;
    logic          tens_q, prev_valid_q, wrap_q, wrap_d, blank;
    logic [DW-1:0] div_q, div_d;
    dig_sel_e      sel_q, sel_d;
    logic [6:0]    seg_q, seg_d, seg_enc;
    logic [1:0]    an_q, an_d, an_on;

    seg7_encode #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc (
        .digit_i(digit),
        .seg_o  (seg_enc)
    );

    always_comb begin
        ones_d = cnt_q >= 4'd10 ? cnt_q - 4'd10 : cnt_q;
        wrap_d = prev_valid_q && cnt_q == 4'd15 && q_in == 4'd0;
        div_d  = div_q == DIV_LAST ? '0 : div_q + 1'b1;
        sel_d  = div_q != DIV_LAST ? sel_q : (sel_q == DIG_ONES ? DIG_TENS : DIG_ONES);
        digit  = sel_q == DIG_TENS ? {3'b000, tens_q} : ones_q;
        an_on  = sel_q == DIG_TENS ? 2'b10 : 2'b01;
`ifdef COUNT_DISP_BLANK_EN
        blank  = sel_q == DIG_TENS && !tens_q;
`else
        blank  = 1'b0;
`endif
        seg_d  = blank ? SEG_OFF : seg_enc;
        an_d   = blank ? AN_OFF : (SEG_ACTIVE_LOW ? ~an_on : an_on);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            prev_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
            tens_q       <= 1'b0;
            ones_q       <= '0;
            div_q        <= '0;
            sel_q        <= DIG_ONES;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
        end else begin
            cnt_q        <= q_in;
            prev_valid_q <= 1'b1;
            wrap_q       <= wrap_d;
            tens_q       <= cnt_q >= 4'd10;
            ones_q       <= ones_d;
            div_q        <= div_d;
            sel_q        <= sel_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_count_seg_display.sv
// tb_count_seg_display: directed stimulus pushes hand-computed expectations, tagged with the
// cycle they are due, into a scoreboard; a negedge monitor pops and compares them.
module tb_count_seg_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] q_in = 4'd0;
    logic [6:0] seg_a, seg_b;
    logic [1:0] an_a, an_b;
    logic       wrap_a, wrap_b;
    int         t = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        int         at;
        bit         b;
        bit         wonly;
        logic [6:0] seg;
        logic [1:0] an;
        logic       w;
        string      nm;
    } exp_t;

    exp_t sb[$];

`ifdef COUNT_DISP_BLANK_EN
    localparam logic [6:0] TSEG0 = 7'h7F;
    localparam logic [1:0] TAN0  = 2'b11;
`else
    localparam logic [6:0] TSEG0 = 7'h40;
    localparam logic [1:0] TAN0  = 2'b01;
`endif

    count_seg_display #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .q_in(q_in),
        .seg (seg_a),
        .an  (an_a),
        .wrap(wrap_a)
    );

    count_seg_display #(.REFRESH_DIV(1), .SEG_ACTIVE_LOW(1'b1)) dut_b (
        .clk (clk),
        .rst (rst),
        .q_in(q_in),
        .seg (seg_b),
        .an  (an_b),
        .wrap(wrap_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) t <= t + 1;

    function automatic void push(int at, bit b, bit wonly, logic [6:0] s, logic [1:0] a, logic w, string nm);
        exp_t e;
        e.at = at; e.b = b; e.wonly = wonly; e.seg = s; e.an = a; e.w = w; e.nm = nm;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [6:0] s;
        logic [1:0] a;
        logic       w;
        while (sb.size() > 0 && sb[0].at <= t) begin
            e = sb.pop_front();
            s = e.b ? seg_b : seg_a;
            a = e.b ? an_b : an_a;
            w = e.b ? wrap_b : wrap_a;
            checks++;
            if (e.wonly ? (w !== e.w) : ({s, a, w} !== {e.seg, e.an, e.w})) begin
                errors++;
                $display("FAIL %s t=%0d: got seg=%h an=%b wrap=%b, want seg=%h an=%b wrap=%b%s",
                         e.nm, t, s, a, w, e.seg, e.an, e.w, e.wonly ? " (wrap only)" : "");
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tick(1);
        for (int d = 2; d <= 4; d++) push(d, 0, 0, 7'h7F, 2'b11, 1'b0, "reset");
        tick(3);
        rst = 1'b0; q_in = 4'd7;
        push(8,  0, 0, 7'h78, 2'b10, 1'b0, "ones7");
        push(10, 0, 0, TSEG0, TAN0,  1'b0, "tens7_a");
        push(12, 0, 0, TSEG0, TAN0,  1'b0, "tens7_b");
        push(14, 0, 0, 7'h78, 2'b10, 1'b0, "ones7_again");
        tick(10);
        q_in = 4'd13;
        push(18, 0, 0, 7'h79, 2'b01, 1'b0, "tens13");
        push(22, 0, 0, 7'h30, 2'b10, 1'b0, "ones13");
        tick(8);
        push(24, 0, 1, 7'h00, 2'b00, 1'b0, "pre_wrap");
        push(25, 0, 1, 7'h00, 2'b00, 1'b1, "wrap");
        push(26, 0, 1, 7'h00, 2'b00, 1'b0, "wrap_one_cycle");
        push(28, 0, 1, 7'h00, 2'b00, 1'b0, "15to3_a");
        push(29, 0, 1, 7'h00, 2'b00, 1'b0, "15to3_b");
        q_in = 4'd14; tick(1);
        q_in = 4'd15; tick(1);
        q_in = 4'd0;  tick(1);
        q_in = 4'd1;  tick(1);
        q_in = 4'd15; tick(1);
        q_in = 4'd3;  tick(1);
        q_in = 4'd5;
        for (int i = 0; i < 16; i++)
            push(33 + i, 0, 0, ((i / 4) % 2 == 0) ? TSEG0 : 7'h12,
                 ((i / 4) % 2 == 0) ? TAN0 : 2'b10, 1'b0, "cadence");
        tick(20);
        q_in = 4'd15; tick(1);
        rst = 1'b1;
        push(50, 0, 0, 7'h7F, 2'b11, 1'b0, "mid_reset");
        tick(1);
        rst = 1'b0; q_in = 4'd0;
        push(51, 0, 0, 7'h40, 2'b10, 1'b0, "post_reset");
        push(52, 0, 0, 7'h40, 2'b10, 1'b0, "no_wrap_span");
        for (int i = 0; i < 6; i++)
            push(53 + i, 1, 0, (i % 2 == 1) ? TSEG0 : 7'h40,
                 (i % 2 == 1) ? TAN0 : 2'b10, 1'b0, "div1_toggle");
        tick(10);
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_drain: %0d expectations pending, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
